// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ctrl_pkg;

    // Opcode field values, 6 bits wide; the top zero-extends to OPCODE_W.
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select.
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Controller states; codes 12-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALU_WB   = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Full datapath control word.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control word decode for the multi-cycle controller.
// Latency: zero cycles (pure combinational).
// Backpressure: mem_ready only qualifies the FETCH PC/IR loads; otherwise ignored.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   op_illegal,
    output ctrl_t  ctrl
);

    // Moore decode of the registered state; everything not named stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                // PC and IR only advance once the instruction word arrives.
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMMSH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = op_illegal;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM (fetch/decode/execute/memory/writeback); optional CTRL_PERF_CNT_EN adds instr_count.
// Latency: 3 cycles BEQ/J, 4 cycles R/ADDI/SW, 5 cycles LW, +1 per stalled mem_ready cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready; other states ignore it.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
`ifdef CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]    instr_count,
`endif
    output logic [3:0]          state
);

    if (OPCODE_W < 6) begin : g_opcode_w_check
        $error("OPCODE_W must be at least 6");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    localparam logic [OPCODE_W-1:0] R_OP    = OPCODE_W'(OP_R);
    localparam logic [OPCODE_W-1:0] LW_OP   = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] SW_OP   = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] BEQ_OP  = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] J_OP    = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] ADDI_OP = OPCODE_W'(OP_ADDI);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                op_illegal;
    ctrl_t               ctrl_raw;
    ctrl_t               ctrl;

    // Unknown opcodes are flagged here and acted on only in DECODE.
    always_comb begin
        op_illegal = !(opcode == R_OP || opcode == LW_OP || opcode == SW_OP ||
                       opcode == BEQ_OP || opcode == J_OP || opcode == ADDI_OP);
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Opcode latch so MEM_ADDR can pick load vs store after the IR moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   op_q <= '0;
        else if (state_q == S_DECODE) op_q <= opcode;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == LW_OP || opcode == SW_OP) state_d = S_MEM_ADDR;
                else if (opcode == R_OP)                state_d = S_EXECUTE;
                else if (opcode == ADDI_OP)             state_d = S_ADDI_EX;
                else if (opcode == BEQ_OP)              state_d = S_BRANCH;
                else if (opcode == J_OP)                state_d = S_JUMP;
                else                                    state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (op_q == SW_OP) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .state      (state_q),
        .mem_ready  (mem_ready),
        .op_illegal (op_illegal),
        .ctrl       (ctrl_raw)
    );

    // Hold every control line low while reset is asserted.
    always_comb begin
        ctrl = reset ? '0 : ctrl_raw;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    // An instruction retires when a completing state hands back to FETCH.
    always_comb begin
        retire = (state_d == S_FETCH) &&
                 (state_q inside {S_MEM_WB, S_MEM_WR, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP});
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a per-cycle expected-output scoreboard.
// Latency: checks each cycle on the falling edge after driving inputs post rising edge.
// Backpressure: exercises mem_ready stalls in FETCH and MEM_WR, and ignored mem_ready elsewhere.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pcw_seen = 0;
    int mw_seen  = 0;
    int rw_seen  = 0;
    logic [20:0] sb[$];

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    always #5 clk = ~clk;

    multicycle_controller #(.OPCODE_W(6), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
`ifdef CTRL_PERF_CNT_EN
        .instr_count   (instr_count),
`endif
        .state         (state)
    );

    // Expected outputs per state, written from the state table.
    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic rdy, input logic ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, ps;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; asb = 2'b10; end
            4'd9:  rw = 1;
            4'd10: begin asa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
            4'd11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {st, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compare the DUT outputs against the oldest scoreboard entry.
    task automatic compare_head(input string tag);
        logic [20:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, {11'd0, obs_vec()}, {11'd0, e});
        end
    endtask

    // One clock with reset asserted: every output (and state) reads 0.
    task automatic rst_cyc(input string tag);
        sb.push_back(21'd0);
        @(negedge clk);
        compare_head(tag);
        @(posedge clk); #1;
    endtask

    // One functional clock: drive inputs, queue expectation, check, advance.
    task automatic cyc(input string tag, input logic [3:0] st, input logic rdy,
                       input logic [5:0] op, input logic ill);
        mem_ready = rdy;
        opcode    = op;
        sb.push_back(exp_vec(st, rdy, ill));
        @(negedge clk);
        pcw_seen += int'(pc_write);
        mw_seen  += int'(mem_write);
        rw_seen  += int'(reg_write);
        compare_head(tag);
        @(posedge clk); #1;
    endtask

    initial begin
`ifdef CTRL_PERF_CNT_EN
        logic [31:0] cnt_before;
`endif
        reset = 1'b1; mem_ready = 1'b1; opcode = RT;
        rst_cyc("reset_c0");
        rst_cyc("reset_c1");
        reset = 1'b0;

        // LW, no stalls: 0,1,2,3,4
        cyc("lw_fetch",  4'd0, 1, LW, 0);
        cyc("lw_decode", 4'd1, 1, LW, 0);
        cyc("lw_maddr",  4'd2, 1, LW, 0);
        cyc("lw_mrd",    4'd3, 1, LW, 0);
        cyc("lw_mwb",    4'd4, 1, LW, 0);
`ifdef CTRL_PERF_CNT_EN
        chk("cnt_after_lw", instr_count, 32'd1);
`endif

        // SW with three stalled cycles in MEM_WR; opcode changes after DECODE.
        mw_seen = 0; rw_seen = 0;
        cyc("sw_fetch",  4'd0, 1, SW, 0);
        cyc("sw_decode", 4'd1, 1, SW, 0);
        cyc("sw_maddr",  4'd2, 1, RT, 0);
        cyc("sw_mwr0",   4'd5, 0, RT, 0);
        cyc("sw_mwr1",   4'd5, 0, RT, 0);
        cyc("sw_mwr2",   4'd5, 0, RT, 0);
        cyc("sw_mwr3",   4'd5, 1, RT, 0);
        chk("sw_mem_write_cycles", mw_seen, 32'd4);
        chk("sw_no_reg_write", rw_seen, 32'd0);

        // FETCH stalled twice, then the illegal opcode.
        pcw_seen = 0;
        cyc("fetch_stall0", 4'd0, 0, BAD, 0);
        cyc("fetch_stall1", 4'd0, 0, BAD, 0);
        cyc("fetch_go",     4'd0, 1, BAD, 0);
        chk("fetch_pc_write_pulses", pcw_seen, 32'd1);
`ifdef CTRL_PERF_CNT_EN
        cnt_before = instr_count;
        chk("cnt_before_illegal", cnt_before, 32'd2);
`endif
        cyc("illegal_decode", 4'd1, 1, BAD, 1);
        cyc("illegal_back",   4'd0, 1, RT,  0);
`ifdef CTRL_PERF_CNT_EN
        chk("cnt_illegal_unchanged", instr_count, cnt_before);
`endif

        // R (mem_ready low in EXECUTE is ignored), ADDI, BEQ, J.
        cyc("r_decode", 4'd1, 1, RT, 0);
        cyc("r_exec",   4'd6, 0, RT, 0);
        cyc("r_wb",     4'd7, 1, RT, 0);
        cyc("addi_fetch",  4'd0, 1, ADDI, 0);
        cyc("addi_decode", 4'd1, 1, ADDI, 0);
        cyc("addi_ex",     4'd8, 0, ADDI, 0);
        cyc("addi_wb",     4'd9, 1, ADDI, 0);
        cyc("beq_fetch",  4'd0, 1, BEQ, 0);
        cyc("beq_decode", 4'd1, 1, BEQ, 0);
        cyc("beq_branch", 4'd10, 1, BEQ, 0);
        cyc("j_fetch",  4'd0, 1, JMP, 0);
        cyc("j_decode", 4'd1, 1, JMP, 0);
        cyc("j_jump",   4'd11, 1, JMP, 0);
`ifdef CTRL_PERF_CNT_EN
        chk("cnt_after_four", instr_count - cnt_before, 32'd4);
`endif

        // Reset asserted in ADDI_EX aborts immediately.
        cyc("abort_fetch",  4'd0, 1, ADDI, 0);
        cyc("abort_decode", 4'd1, 1, ADDI, 0);
        chk("abort_pre_state", {28'd0, state}, 32'd8);
        reset = 1'b1;
        #1;
        chk("abort_async_state", {28'd0, state}, 32'd0);
        rst_cyc("abort_reset");
`ifdef CTRL_PERF_CNT_EN
        chk("abort_cnt_cleared", instr_count, 32'd0);
`endif
        reset = 1'b0;
        cyc("post_abort_fetch", 4'd0, 1, RT, 0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
